// File: rtl/pio_pkg.sv
// Shared constants for the multi-channel edge-interrupt PIO.
package pio_pkg;

  localparam int unsigned PIO_AW = 3;

  localparam logic [PIO_AW-1:0] PIO_ADDR_DATA = 3'd0;
  localparam logic [PIO_AW-1:0] PIO_ADDR_RISE = 3'd1;
  localparam logic [PIO_AW-1:0] PIO_ADDR_MASK = 3'd2;
  localparam logic [PIO_AW-1:0] PIO_ADDR_CAP  = 3'd3;
  localparam logic [PIO_AW-1:0] PIO_ADDR_FALL = 3'd4;
  localparam logic [PIO_AW-1:0] PIO_ADDR_DB   = 3'd5;

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: 2-flop synchroniser, debounce filter, edge detect.
module pio_debounce_ch
  import pio_pkg::*;
#(
  parameter int unsigned DB_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_in,
  input  logic [DB_W-1:0] i_db,
  output logic            o_st,
  output logic            o_rise_raw,
  output logic            o_fall_raw
);

  logic            r_s1;
  logic            r_s2;
  logic            r_st;
  logic            r_st_d;
  logic            r_rise;
  logic            r_fall;
  logic [DB_W-1:0] r_cnt;

  // Edge flags are registered: detect is its own pipeline stage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_st   <= 1'b0;
      r_st_d <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_in;
      r_s2   <= r_s1;
      r_st_d <= r_st;
      r_rise <= r_st & ~r_st_d;
      r_fall <= ~r_st & r_st_d;
      if (r_s2 == r_st) begin
        r_cnt <= '0;
      end else if (r_cnt >= i_db) begin
        r_st  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
  end

  assign o_st       = r_st;
  assign o_rise_raw = r_rise;
  assign o_fall_raw = r_fall;

endmodule

// File: rtl/pio_edge_irq_multi.sv
// N-channel Avalon-MM input PIO with debounce and per-channel edge IRQ.
module pio_edge_irq_multi
  import pio_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter int unsigned     DB_W     = 16,
  parameter logic [DB_W-1:0] DB_RESET = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PIO_AW-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [DB_W-1:0]  r_db;
  logic [31:0]      r_rdata;

  logic [WIDTH-1:0] w_st;
  logic [WIDTH-1:0] w_rise_raw;
  logic [WIDTH-1:0] w_fall_raw;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd;
  logic             w_wr;
  logic             w_unused;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    pio_debounce_ch #(.DB_W(DB_W)) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_in      (in_port[g]),
      .i_db      (r_db),
      .o_st      (w_st[g]),
      .o_rise_raw(w_rise_raw[g]),
      .o_fall_raw(w_fall_raw[g])
    );
  end

  assign w_wr     = chipselect & ~write_n;
  assign w_ev     = (w_rise_raw & r_rise_en) | (w_fall_raw & r_fall_en);
  assign w_clr    = (w_wr && address == PIO_ADDR_CAP) ?
                    writedata[WIDTH-1:0] : '0;
  assign w_unused = ^writedata;

  always_comb begin
    w_rd = '0;
    case (address)
      PIO_ADDR_DATA: w_rd[WIDTH-1:0] = w_st;
      PIO_ADDR_RISE: w_rd[WIDTH-1:0] = r_rise_en;
      PIO_ADDR_MASK: w_rd[WIDTH-1:0] = r_mask;
      PIO_ADDR_CAP:  w_rd[WIDTH-1:0] = r_cap;
      PIO_ADDR_FALL: w_rd[WIDTH-1:0] = r_fall_en;
      PIO_ADDR_DB:   w_rd[DB_W-1:0]  = r_db;
      default:       w_rd = '0;
    endcase
  end

  // A new event wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_mask    <= '0;
      r_cap     <= '0;
      r_db      <= DB_RESET;
      r_rdata   <= '0;
    end else begin
      r_rdata <= w_rd;
      r_cap   <= (r_cap & ~w_clr) | w_ev;
      if (w_wr && address == PIO_ADDR_RISE)
        r_rise_en <= writedata[WIDTH-1:0];
      if (w_wr && address == PIO_ADDR_FALL)
        r_fall_en <= writedata[WIDTH-1:0];
      if (w_wr && address == PIO_ADDR_MASK)
        r_mask <= writedata[WIDTH-1:0];
      if (w_wr && address == PIO_ADDR_DB)
        r_db <= writedata[DB_W-1:0];
    end
  end

  assign readdata = r_rdata;
  assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_pio_edge_irq_multi.sv
// Directed self-checking bench for pio_edge_irq_multi.
module tb_pio_edge_irq_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  pio_edge_irq_multi #(
    .WIDTH   (4),
    .DB_W    (16),
    .DB_RESET(16'd7)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [2:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    tick(3);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    reset_n = 1'b1;

    rd_chk("rst_data", 3'd0, 32'h0);
    rd_chk("rst_rise", 3'd1, 32'h0);
    rd_chk("rst_mask", 3'd2, 32'h0);
    rd_chk("rst_cap", 3'd3, 32'h0);
    rd_chk("rst_fall", 3'd4, 32'h0);
    rd_chk("rst_db", 3'd5, 32'd7);
    rd_chk("rst_a6", 3'd6, 32'h0);
    rd_chk("rst_a7", 3'd7, 32'h0);

    tick(20);
    rd_chk("settle_data", 3'd0, 32'hF);
    rd_chk("settle_cap", 3'd3, 32'h0);
    chk("settle_irq", {31'd0, irq}, 32'd0);

    wr(3'd5, 32'd0);
    in_port = 4'h0;
    tick(10);
    rd_chk("idle_data", 3'd0, 32'h0);

    // Rising edge, no debounce: irq after exactly 5 edges.
    wr(3'd1, 32'h1);
    wr(3'd2, 32'h1);
    in_port[0] = 1'b1;
    tick(4);
    chk("rise_irq_early", {31'd0, irq}, 32'd0);
    tick();
    chk("rise_irq", {31'd0, irq}, 32'd1);
    rd_chk("rise_cap", 3'd3, 32'h1);
    wr(3'd3, 32'h1);
    chk("rise_clr_irq", {31'd0, irq}, 32'd0);
    rd_chk("rise_clr_cap", 3'd3, 32'h0);

    // Falling edge only on channel 2.
    in_port = 4'h0;
    tick(8);
    wr(3'd4, 32'h4);
    in_port[2] = 1'b1;
    tick(8);
    rd_chk("fall_rise_ign", 3'd3, 32'h0);
    in_port[2] = 1'b0;
    tick(8);
    rd_chk("fall_cap", 3'd3, 32'h4);
    wr(3'd3, 32'h4);
    in_port[2] = 1'b1;
    tick(8);
    rd_chk("fall_no_rise", 3'd3, 32'h0);
    rd_chk("fall_data", 3'd0, 32'h4);

    // Debounce: 8-cycle glitch filtered, held level captured.
    wr(3'd5, 32'd10);
    wr(3'd1, 32'h2);
    wr(3'd2, 32'h2);
    rd_chk("db_reg", 3'd5, 32'd10);
    in_port[1] = 1'b1;
    tick(8);
    in_port[1] = 1'b0;
    tick(20);
    rd_chk("db_glitch_cap", 3'd3, 32'h0);
    chk("db_glitch_irq", {31'd0, irq}, 32'd0);
    in_port[1] = 1'b1;
    tick(14);
    chk("db_irq_early", {31'd0, irq}, 32'd0);
    tick();
    chk("db_irq", {31'd0, irq}, 32'd1);
    rd_chk("db_cap", 3'd3, 32'h2);
    wr(3'd3, 32'h2);
    chk("db_clr_irq", {31'd0, irq}, 32'd0);

    // Clear collides with a new event on channel 3.
    wr(3'd5, 32'd0);
    wr(3'd1, 32'h8);
    tick(2);
    in_port[3] = 1'b1;
    tick(4);
    wr(3'd3, 32'h8);
    rd_chk("set_clr_cap", 3'd3, 32'h8);

    // Mask gating and selective W1C.
    wr(3'd4, 32'h2);
    in_port[1] = 1'b0;
    tick(8);
    rd_chk("mask_cap", 3'd3, 32'hA);
    wr(3'd2, 32'h5);
    chk("mask5_irq", {31'd0, irq}, 32'd0);
    wr(3'd2, 32'h2);
    chk("mask2_irq", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h2);
    chk("w1c_irq", {31'd0, irq}, 32'd0);
    rd_chk("w1c_cap", 3'd3, 32'h8);

    // Upper write bits ignored; unmapped addresses read zero.
    wr(3'd1, 32'hFFFF_FFF5);
    rd_chk("wide_rise", 3'd1, 32'h5);
    wr(3'd6, 32'hFFFF_FFFF);
    rd_chk("a6_wr", 3'd6, 32'h0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd_chk("a7_wr", 3'd7, 32'h0);
    chk("final_irq", {31'd0, irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
